// File: rtl/node_pkg.sv
// Shared types and helpers for the NoC node serialiser/deserialiser.
package node_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

    localparam int STAT_W = 16;

    function automatic int calc_nflit(input int pkt_w, input int flit_w);
        return pkt_w / flit_w;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/node_fifo.sv
// First-word fall-through packet queue; pointers wrap at DEPTH, so DEPTH
// need not be a power of two.
module node_fifo
    import node_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same edge, so a full queue still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count/pointers alone define validity and
    // leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/noc_node_serdes.sv
// NoC endpoint: queues TB packets and serialises them to the router, and
// reassembles router flits into packets. Define NODE_STATS_EN for counters.
module noc_node_serdes
    import node_pkg::*;
#(
    parameter int NODEID = 0,
    parameter int PKT_W  = 32,
    parameter int FLIT_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [FLIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [FLIT_W-1:0] payload_inbound
`ifdef NODE_STATS_EN
    ,
    output logic [STAT_W-1:0] tx_pkts,
    output logic [STAT_W-1:0] rx_pkts,
    output logic [STAT_W-1:0] drop_pkts
`endif
);

    localparam int NFLIT = calc_nflit(PKT_W, FLIT_W);
    localparam int CNT_W = (NFLIT > 1) ? $clog2(NFLIT) : 1;

    if ((PKT_W % FLIT_W) != 0 || NFLIT < 2 || DEPTH < 2) begin : g_bad_cfg
        $error("noc_node_serdes: PKT_W must be a multiple of FLIT_W with NFLIT >= 2 and DEPTH >= 2");
    end

    logic [PKT_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             tx_pop;

    node_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (pkt_in_avail),
        .push_data (pkt_in),
        .pop       (tx_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign cQ_full = fifo_full;

    // ---------------- serialiser ----------------
    tx_state_t        tx_state;
    logic [PKT_W-1:0] tx_sr;
    logic [CNT_W-1:0] tx_cnt;

    assign tx_pop = (tx_state == TX_IDLE) && !fifo_empty && free_outbound;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_state         <= TX_IDLE;
            tx_sr            <= '0;
            tx_cnt           <= '0;
            put_outbound     <= 1'b0;
            payload_outbound <= '0;
        end else begin
            put_outbound     <= 1'b0;
            payload_outbound <= '0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_sr    <= fifo_head;
                        tx_cnt   <= '0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // Once started, the packet streams out regardless of free_outbound.
                    put_outbound     <= 1'b1;
                    payload_outbound <= tx_sr[PKT_W-1 -: FLIT_W];
                    tx_sr            <= tx_sr << FLIT_W;
                    tx_cnt           <= tx_cnt + 1'b1;
                    if (tx_cnt == CNT_W'(NFLIT - 1)) begin
                        tx_state <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- deserialiser ----------------
    rx_state_t               rx_state;
    logic [PKT_W-FLIT_W-1:0] rx_sr;
    logic [CNT_W-1:0]        rx_cnt;
    logic [PKT_W-1:0]        rx_next;

    // Earlier flits sit above the incoming one, so flit 0 ends in the MSBs.
    assign rx_next       = {rx_sr, payload_inbound};
    assign free_inbound  = (rx_state == RX_IDLE);
    assign pkt_out_avail = (rx_state == RX_DONE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_sr    <= '0;
            rx_cnt   <= '0;
            pkt_out  <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (put_inbound) begin
                        rx_sr    <= rx_next[PKT_W-FLIT_W-1:0];
                        rx_cnt   <= CNT_W'(1);
                        rx_state <= RX_RECV;
                    end
                end
                RX_RECV: begin
                    if (put_inbound) begin
                        rx_sr <= rx_next[PKT_W-FLIT_W-1:0];
                        if (rx_cnt == CNT_W'(NFLIT - 1)) begin
                            pkt_out  <= rx_next;
                            rx_state <= RX_DONE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                RX_DONE: rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assert property (@(posedge clock) disable iff (!reset_n)
                     (rx_state == RX_DONE) |-> !put_inbound)
        else $error("noc_node_serdes node %0d: put_inbound while delivering a packet", NODEID);

`ifdef NODE_STATS_EN
    logic push_drop;

    assign push_drop = pkt_in_avail && fifo_full && !tx_pop;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_pkts   <= '0;
            rx_pkts   <= '0;
            drop_pkts <= '0;
        end else begin
            if (tx_pop)        tx_pkts   <= sat_inc(tx_pkts);
            if (pkt_out_avail) rx_pkts   <= sat_inc(rx_pkts);
            if (push_drop)     drop_pkts <= sat_inc(drop_pkts);
        end
    end
`endif

endmodule

// File: tb/tb_noc_node_serdes.sv
// Directed bench for noc_node_serdes: default 32/8/4 instance plus a 48/16/3
// instance for non-power-of-two pointer wrap.
module tb_noc_node_serdes;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: defaults
    logic [31:0] a_pkt_in;
    logic        a_pkt_in_avail;
    logic        a_cq_full;
    logic [31:0] a_pkt_out;
    logic        a_pkt_out_avail;
    logic        a_free_outbound;
    logic        a_put_outbound;
    logic [7:0]  a_payload_outbound;
    logic        a_free_inbound;
    logic        a_put_inbound;
    logic [7:0]  a_payload_inbound;

    // Instance B: DEPTH=3, PKT_W=48, FLIT_W=16
    logic [47:0] b_pkt_in;
    logic        b_pkt_in_avail;
    logic        b_cq_full;
    logic [47:0] b_pkt_out;
    logic        b_pkt_out_avail;
    logic        b_free_outbound;
    logic        b_put_outbound;
    logic [15:0] b_payload_outbound;
    logic        b_free_inbound;

`ifdef NODE_STATS_EN
    logic [15:0] a_tx_pkts, a_rx_pkts, a_drop_pkts;
    logic [15:0] b_tx_pkts, b_rx_pkts, b_drop_pkts;
`endif

    noc_node_serdes #(.NODEID(0), .PKT_W(32), .FLIT_W(8), .DEPTH(4)) u_dut_a (
        .clock            (clock),
        .reset_n          (reset_n),
        .pkt_in           (a_pkt_in),
        .pkt_in_avail     (a_pkt_in_avail),
        .cQ_full          (a_cq_full),
        .pkt_out          (a_pkt_out),
        .pkt_out_avail    (a_pkt_out_avail),
        .free_outbound    (a_free_outbound),
        .put_outbound     (a_put_outbound),
        .payload_outbound (a_payload_outbound),
        .free_inbound     (a_free_inbound),
        .put_inbound      (a_put_inbound),
        .payload_inbound  (a_payload_inbound)
`ifdef NODE_STATS_EN
        ,
        .tx_pkts          (a_tx_pkts),
        .rx_pkts          (a_rx_pkts),
        .drop_pkts        (a_drop_pkts)
`endif
    );

    noc_node_serdes #(.NODEID(1), .PKT_W(48), .FLIT_W(16), .DEPTH(3)) u_dut_b (
        .clock            (clock),
        .reset_n          (reset_n),
        .pkt_in           (b_pkt_in),
        .pkt_in_avail     (b_pkt_in_avail),
        .cQ_full          (b_cq_full),
        .pkt_out          (b_pkt_out),
        .pkt_out_avail    (b_pkt_out_avail),
        .free_outbound    (b_free_outbound),
        .put_outbound     (b_put_outbound),
        .payload_outbound (b_payload_outbound),
        .free_inbound     (b_free_inbound),
        .put_inbound      (1'b0),
        .payload_inbound  (16'h0000)
`ifdef NODE_STATS_EN
        ,
        .tx_pkts          (b_tx_pkts),
        .rx_pkts          (b_rx_pkts),
        .drop_pkts        (b_drop_pkts)
`endif
    );

    logic [7:0]  a_flits [$];
    logic [15:0] b_flits [$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One rising edge; returns at the following falling edge where outputs are stable.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic collect_a(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (a_put_outbound) a_flits.push_back(a_payload_outbound);
        end
    endtask

    function automatic logic [31:0] a_packet(input int j);
        return {a_flits[4*j], a_flits[4*j+1], a_flits[4*j+2], a_flits[4*j+3]};
    endfunction

    function automatic logic [47:0] b_model(input int i);
        return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i)};
    endfunction

    logic [31:0] t1_pkt = 32'hA1B2C3D4;
    logic [31:0] t2_pkts [5] = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};
    logic [31:0] t5_pkts [5] = '{32'h50000001, 32'h50000002, 32'h50000003, 32'h50000004, 32'h50000005};
    logic [7:0]  t3_flits [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0]  t4_flits [4] = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial begin
        int b_pushed;

        reset_n           = 1'b0;
        a_pkt_in          = '0;
        a_pkt_in_avail    = 1'b0;
        a_free_outbound   = 1'b0;
        a_put_inbound     = 1'b0;
        a_payload_inbound = '0;
        b_pkt_in          = '0;
        b_pkt_in_avail    = 1'b0;
        b_free_outbound   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_cq_full",   64'(a_cq_full),          64'd0);
        check("rst_put_out",   64'(a_put_outbound),     64'd0);
        check("rst_payload",   64'(a_payload_outbound), 64'd0);
        check("rst_free_in",   64'(a_free_inbound),     64'd1);
        check("rst_pkt_out",   64'(a_pkt_out),          64'd0);
        check("rst_pkt_avail", 64'(a_pkt_out_avail),    64'd0);
        reset_n = 1'b1;
        tick();

        // Single packet: flit 0 two edges after the push edge
        a_free_outbound = 1'b1;
        a_pkt_in        = t1_pkt;
        a_pkt_in_avail  = 1'b1;
        tick();
        a_pkt_in_avail = 1'b0;
        check("t1_put_k", 64'(a_put_outbound), 64'd0);
        tick();
        check("t1_put_k1", 64'(a_put_outbound), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_put",  64'(a_put_outbound),     64'd1);
            check("t1_flit", 64'(a_payload_outbound), 64'(t1_pkt[31-8*i -: 8]));
        end
        tick();
        check("t1_put_gap", 64'(a_put_outbound), 64'd0);
        tick();
        tick();
        check("t1_queue_empty", 64'(a_put_outbound), 64'd0);
        check("t1_cq_full",     64'(a_cq_full),      64'd0);

        // Fill while blocked, drop the 5th, then drain in order
        a_free_outbound = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_pkt_in       = t2_pkts[i];
            a_pkt_in_avail = 1'b1;
            tick();
            check("t2_cq_full", 64'(a_cq_full), 64'(i >= 3));
        end
        a_pkt_in_avail = 1'b0;
        a_flits.delete();
        a_free_outbound = 1'b1;
        collect_a(30);
        check("t2_flit_count", 64'(a_flits.size()), 64'd16);
        for (int j = 0; j < 4; j++) check("t2_pkt_order", 64'(a_packet(j)), 64'(t2_pkts[j]));
        check("t2_cq_drained", 64'(a_cq_full), 64'd0);
`ifdef NODE_STATS_EN
        check("t2_drop_pkts", 64'(a_drop_pkts), 64'd1);
        check("t2_tx_pkts",   64'(a_tx_pkts),   64'd5);
`endif

        // Back-to-back inbound flits
        for (int i = 0; i < 4; i++) begin
            a_put_inbound     = 1'b1;
            a_payload_inbound = t3_flits[i];
            tick();
            if (i < 3) begin
                check("t3_free_in", 64'(a_free_inbound),  64'd0);
                check("t3_no_avail", 64'(a_pkt_out_avail), 64'd0);
            end
        end
        a_put_inbound = 1'b0;
        check("t3_avail",   64'(a_pkt_out_avail), 64'd1);
        check("t3_pkt_out", 64'(a_pkt_out),       64'h12345678);
        check("t3_free_dn", 64'(a_free_inbound),  64'd0);
        tick();
        check("t3_avail_1cyc", 64'(a_pkt_out_avail), 64'd0);
        check("t3_free_back",  64'(a_free_inbound),  64'd1);
        check("t3_pkt_hold",   64'(a_pkt_out),       64'h12345678);

        // Inbound flits with two-cycle gaps
        for (int i = 0; i < 4; i++) begin
            a_put_inbound     = 1'b1;
            a_payload_inbound = t4_flits[i];
            tick();
            a_put_inbound = 1'b0;
            if (i < 3) begin
                tick();
                check("t4_gap_avail", 64'(a_pkt_out_avail), 64'd0);
                tick();
                check("t4_gap_free",  64'(a_free_inbound),  64'd0);
                check("t4_gap_hold",  64'(a_pkt_out),       64'h12345678);
            end
        end
        check("t4_avail",   64'(a_pkt_out_avail), 64'd1);
        check("t4_pkt_out", 64'(a_pkt_out),       64'h9ABCDEF0);
        tick();
        check("t4_avail_1cyc", 64'(a_pkt_out_avail), 64'd0);
        check("t4_free_back",  64'(a_free_inbound),  64'd1);

        // Full queue: push and pop on the same edge
        a_free_outbound = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_pkt_in       = t5_pkts[i];
            a_pkt_in_avail = 1'b1;
            tick();
        end
        check("t5_full_before", 64'(a_cq_full), 64'd1);
        a_pkt_in        = t5_pkts[4];
        a_free_outbound = 1'b1;
        tick();
        a_pkt_in_avail = 1'b0;
        check("t5_full_pushpop", 64'(a_cq_full), 64'd1);
        a_flits.delete();
        collect_a(30);
        check("t5_flit_count", 64'(a_flits.size()), 64'd20);
        for (int j = 0; j < 5; j++) check("t5_pkt_order", 64'(a_packet(j)), 64'(t5_pkts[j]));
`ifdef NODE_STATS_EN
        check("t5_tx_pkts",   64'(a_tx_pkts),   64'd10);
        check("t5_rx_pkts",   64'(a_rx_pkts),   64'd2);
        check("t5_drop_pkts", 64'(a_drop_pkts), 64'd1);
`endif

        // Pointer wrap on DEPTH=3: 10 packets, pushes aligned with pops while full
        b_pushed = 0;
        for (int t = 1; t <= 60; t++) begin
            b_pkt_in_avail  = (t <= 4) || (t <= 28 && (t % 4) == 0);
            b_pkt_in        = b_model(b_pushed);
            b_free_outbound = (t >= 4);
            tick();
            if (b_pkt_in_avail) b_pushed++;
            b_pkt_in_avail = 1'b0;
            if (t == 3 || t == 4 || t == 16) check("b_cq_full", 64'(b_cq_full), 64'd1);
            if (b_put_outbound) b_flits.push_back(b_payload_outbound);
        end
        check("b_flit_count", 64'(b_flits.size()), 64'd30);
        for (int j = 0; j < 10; j++)
            check("b_pkt_order", 64'({b_flits[3*j], b_flits[3*j+1], b_flits[3*j+2]}), 64'(b_model(j)));
        check("b_cq_drained", 64'(b_cq_full), 64'd0);

        // Reset mid-SEND and mid-RECV
        a_free_outbound = 1'b1;
        a_pkt_in        = 32'hDEADBEEF;
        a_pkt_in_avail  = 1'b1;
        tick();
        a_pkt_in = 32'hFEEDF00D;
        tick();
        a_pkt_in_avail    = 1'b0;
        a_put_inbound     = 1'b1;
        a_payload_inbound = 8'hAA;
        tick();
        a_payload_inbound = 8'hBB;
        tick();
        a_put_inbound = 1'b0;
        check("t7_mid_send", 64'(a_put_outbound), 64'd1);
        check("t7_mid_recv", 64'(a_free_inbound), 64'd0);
        reset_n = 1'b0;
        tick();
        check("t7_rst_put",     64'(a_put_outbound),     64'd0);
        check("t7_rst_payload", 64'(a_payload_outbound), 64'd0);
        check("t7_rst_free_in", 64'(a_free_inbound),     64'd1);
        check("t7_rst_cq_full", 64'(a_cq_full),          64'd0);
        check("t7_rst_avail",   64'(a_pkt_out_avail),    64'd0);
        check("t7_rst_pkt_out", 64'(a_pkt_out),          64'd0);
`ifdef NODE_STATS_EN
        check("t7_rst_tx_pkts", 64'(a_tx_pkts), 64'd0);
`endif
        reset_n = 1'b1;
        a_flits.delete();
        collect_a(8);
        check("t7_queue_empty", 64'(a_flits.size()),  64'd0);
        check("t7_no_stale",    64'(a_pkt_out_avail), 64'd0);
        for (int i = 0; i < 4; i++) begin
            a_put_inbound     = 1'b1;
            a_payload_inbound = 8'(i + 1);
            tick();
        end
        a_put_inbound = 1'b0;
        check("t7_fresh_avail", 64'(a_pkt_out_avail), 64'd1);
        check("t7_fresh_pkt",   64'(a_pkt_out),       64'h01020304);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
